// File: rtl/ysyx_22041461_ifu_pkg.sv
// Shared fetch-unit constants: reset PC, instruction encodings
// and the layout of a fetch-queue entry {fault, pc, inst}.
package ysyx_22041461_ifu_pkg;

   localparam int          XLEN_DEF     = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

   localparam int          INST_W  = 32;
   localparam int          FAULT_W = 1;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [31:0] FAULT_INST = 32'h0000_0000;

   function automatic int fe_width(input int xlen);
      return FAULT_W + xlen + INST_W;
   endfunction

endpackage

// File: rtl/ysyx_22041461_sync_fifo.sv
// Synchronous FIFO with occupancy count and a one-cycle clear.
// Push while full is accepted only when a pop happens in the same cycle.
module ysyx_22041461_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULLC = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == FULLC);
   assign empty   = (count == '0);
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign dout    = mem[rptr];

   // storage array, no reset so it can map onto plain registers/RAM
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wptr] <= din;
      end
   end

   // pointers and occupancy; clear empties the queue in one cycle
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_en) begin
            wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
         end
         if (pop_en) begin
            rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
         end
         count <= count + CW'(push_en) - CW'(pop_en);
      end
   end

endmodule

// File: rtl/ysyx_22041461_ifu.sv
// Instruction-fetch unit: owns the PC, keeps up to MAX_OUT fetches
// in flight, buffers responses and drops those made stale by a redirect.
module ysyx_22041461_ifu
   import ysyx_22041461_ifu_pkg::*;
#(
   parameter int             XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int             FQ_DEPTH = 4,
   parameter int             MAX_OUT  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_pc,
   input  logic            mem_resp_valid,
   input  logic [31:0]     mem_resp_inst,
   input  logic            mem_resp_err,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_inst,
   output logic            id_fault
);

   localparam int FEW = fe_width(XLEN);
   localparam int CW  = $clog2(FQ_DEPTH + 1);
   localparam int OW  = $clog2(MAX_OUT + 1);
   localparam logic [CW:0]   FQ_LIM  = (CW+1)'(FQ_DEPTH);
   localparam logic [OW-1:0] OUT_LIM = OW'(MAX_OUT);

   logic [XLEN-1:0] pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [OW-1:0]   out_nxt;

   logic [CW-1:0]   fq_count;
   logic [CW:0]     occ;
   logic            credit;
   logic            req_fire;
   logic            resp_ok;

   logic            fq_push;
   logic            fq_pop;
   logic            fq_full;
   logic            fq_empty;
   logic [FEW-1:0]  fq_din;
   logic [FEW-1:0]  fq_dout;

   logic [XLEN-1:0] pcf_dout;
   logic            pcf_full;
   logic            pcf_empty;
   logic [OW-1:0]   pcf_count;

   assign occ    = (CW+1)'(fq_count) + (CW+1)'(outstanding);
   assign credit = (outstanding < OUT_LIM) && (occ < FQ_LIM);

   assign mem_req_valid = !rst && !redirect_valid && credit;
   assign mem_req_pc    = pc;
   assign req_fire      = mem_req_valid && mem_req_ready;

   assign resp_ok = mem_resp_valid && (outstanding != '0);
   assign fq_push = resp_ok && (drop_cnt == '0) && !redirect_valid;

   assign id_valid = !rst && !redirect_valid && !fq_empty;
   assign fq_pop   = id_valid && id_ready;

   assign fq_din = {mem_resp_err, pcf_dout,
                    mem_resp_err ? FAULT_INST : mem_resp_inst};

   assign {id_fault, id_pc, id_inst} = fq_empty ? '0 : fq_dout;

   // in-flight count after this cycle's request and response
   always_comb begin
      out_nxt = outstanding + OW'(req_fire) - OW'(resp_ok);
   end

   // PC, in-flight and stale-response bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= out_nxt;
         if (redirect_valid) begin
            pc       <= redirect_pc & ~XLEN'(3);
            drop_cnt <= out_nxt;
         end else begin
            if (req_fire) begin
               pc <= pc + XLEN'(4);
            end
            if (resp_ok && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - OW'(1);
            end
         end
      end
   end

   ysyx_22041461_sync_fifo #(
      .WIDTH (FEW),
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk   (clk),
      .rst   (rst),
      .clr   (redirect_valid),
      .push  (fq_push),
      .din   (fq_din),
      .pop   (fq_pop),
      .dout  (fq_dout),
      .full  (fq_full),
      .empty (fq_empty),
      .count (fq_count)
   );

   ysyx_22041461_sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUT)
   ) u_pcf (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .push  (req_fire),
      .din   (pc),
      .pop   (resp_ok),
      .dout  (pcf_dout),
      .full  (pcf_full),
      .empty (pcf_empty),
      .count (pcf_count)
   );

   // protocol and internal consistency checks
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(mem_resp_valid && (outstanding == '0)));
         assert (pcf_count == outstanding);
         assert (pcf_empty == (outstanding == '0));
         assert (!(req_fire && pcf_full));
         assert (!(fq_push && fq_full && !fq_pop));
         assert (drop_cnt <= outstanding);
      end
   end

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Bench for ysyx_22041461_ifu: directed vector table, then an ICACHE
// model with random latency/back-pressure checked against a fetch-stream model.
module tb_ysyx_22041461_ifu;

   localparam int          XLEN     = 64;
   localparam int          FQ_DEPTH = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [63:0] RST_PC   = 64'h8000_0000;

   logic            clk;
   logic            rst;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_pc;
   logic            mem_resp_valid;
   logic [31:0]     mem_resp_inst;
   logic            mem_resp_err;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [31:0]     id_inst;
   logic            id_fault;

   ysyx_22041461_ifu #(
      .XLEN     (XLEN),
      .RESET_PC (RST_PC),
      .FQ_DEPTH (FQ_DEPTH),
      .MAX_OUT  (MAX_OUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_pc     (mem_req_pc),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_inst  (mem_resp_inst),
      .mem_resp_err   (mem_resp_err),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_inst        (id_inst),
      .id_fault       (id_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic        rdv;
      logic [63:0] rpc;
      logic        rdy;
      logic        rv;
      logic [31:0] ri;
      logic        re;
      logic        idr;
      logic        erv;
      logic [63:0] epc;
      logic        civ;
      logic        eiv;
      logic        cid;
      logic [63:0] eipc;
      logic [31:0] einst;
      logic        eflt;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic r, input logic rd, input logic [63:0] rp,
      input logic rdy, input logic rv, input logic [31:0] ri,
      input logic re, input logic idr,
      input logic erv, input logic [63:0] epc,
      input logic civ, input logic eiv, input logic cid,
      input logic [63:0] eipc, input logic [31:0] einst,
      input logic eflt);
      vec_t v;
      v.rst = r;  v.rdv = rd; v.rpc = rp;
      v.rdy = rdy; v.rv = rv; v.ri = ri;
      v.re = re;  v.idr = idr;
      v.erv = erv; v.epc = epc;
      v.civ = civ; v.eiv = eiv; v.cid = cid;
      v.eipc = eipc; v.einst = einst; v.eflt = eflt;
      return v;
   endfunction

   // ---------------- ICACHE + fetch-stream model ----------------
   typedef struct {
      logic [63:0] pc;
      int          due;
      int          ep;
   } pend_t;

   pend_t       pending[$];
   logic [63:0] fq[$];
   logic [63:0] exp_req_pc;
   int          ep;
   int          cyc;
   int          lat_lo;
   int          lat_hi;
   int          n_id;
   logic        seen;
   logic [63:0] first_pc;

   function automatic logic [31:0] inst_of(input logic [63:0] p);
      return p[31:0] ^ 32'h1357_9BDF;
   endfunction

   function automatic logic err_of(input logic [63:0] p);
      return p[6:0] == 7'h08;
   endfunction

   task automatic cycle(input logic r, input logic rd,
                        input logic [63:0] tgt,
                        input logic rdy, input logic idr);
      logic  exp_rv;
      logic  exp_iv;
      pend_t e;
      @(negedge clk);
      rst            = r;
      redirect_valid = rd && !r;
      redirect_pc    = tgt;
      mem_req_ready  = rdy;
      id_ready       = idr;
      mem_resp_valid = 1'b0;
      mem_resp_inst  = 32'h0;
      mem_resp_err   = 1'b0;
      if (!r && pending.size() > 0 && pending[0].due <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_inst  = inst_of(pending[0].pc);
         mem_resp_err   = err_of(pending[0].pc);
      end
      #1;
      exp_rv = !r && !redirect_valid && pending.size() < MAX_OUT &&
               (fq.size() + pending.size()) < FQ_DEPTH;
      exp_iv = !r && !redirect_valid && fq.size() > 0;
      chk("req_valid", mem_req_valid, exp_rv);
      if (exp_rv) chk("req_pc", mem_req_pc, exp_req_pc);
      chk("id_valid", id_valid, exp_iv);
      if (exp_iv) begin
         chk("id_pc", id_pc, fq[0]);
         chk("id_inst", id_inst, err_of(fq[0]) ? 32'h0 : inst_of(fq[0]));
         chk("id_fault", id_fault, err_of(fq[0]));
      end
      if (id_valid && id_ready) begin
         n_id++;
         if (!seen) begin
            seen     = 1'b1;
            first_pc = id_pc;
         end
      end
      if (r) begin
         pending.delete();
         fq.delete();
         exp_req_pc = RST_PC;
         ep++;
      end else begin
         if (exp_iv && idr) void'(fq.pop_front());
         if (mem_resp_valid) begin
            e = pending.pop_front();
            if (!redirect_valid && e.ep == ep) fq.push_back(e.pc);
         end
         if (exp_rv && rdy) begin
            e.pc  = exp_req_pc;
            e.due = cyc + int'($urandom_range(lat_hi, lat_lo));
            e.ep  = ep;
            pending.push_back(e);
            exp_req_pc = exp_req_pc + 64'd4;
         end
         if (redirect_valid) begin
            fq.delete();
            exp_req_pc = tgt & ~64'h3;
            ep++;
         end
      end
      cyc++;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_inst  = '0;
      mem_resp_err   = 1'b0;
      id_ready       = 1'b0;
      exp_req_pc     = RST_PC;
      ep = 0; cyc = 0; n_id = 0;
      lat_lo = 1; lat_hi = 1;
      seen = 1'b0; first_pc = '0;

      // rst rd rpc rdy rv ri re idr | erv epc | civ eiv cid eipc einst eflt
      tv.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,0,0,1, 1,64'h80000000, 1,0,1,0,0,0));
      tv.push_back(mk(0,0,0,1,1,32'hA0,0,1, 1,64'h80000004, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,1,32'hA1,0,1, 1,64'h80000008,
                      1,1,1,64'h80000000,32'hA0,0));
      tv.push_back(mk(0,0,0,1,0,0,0,0, 1,64'h80000008,
                      1,1,1,64'h80000004,32'hA1,0));
      tv.push_back(mk(0,0,0,1,1,32'hDEADBEEF,1,1, 1,64'h8000000C,
                      1,1,1,64'h80000004,32'hA1,0));
      tv.push_back(mk(0,0,0,0,0,0,0,1, 1,64'h80000010,
                      1,1,1,64'h80000008,32'h0,1));
      tv.push_back(mk(0,0,0,1,1,32'hA3,0,1, 1,64'h80000010, 1,0,0,0,0,0));
      tv.push_back(mk(0,1,64'h80001002,1,1,32'hA4,0,1, 0,0, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,0,0,1, 1,64'h80001000, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,0,0,1, 1,64'h80001000, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,1,32'hB0,0,1, 1,64'h80001004, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,0,0,1, 1,64'h80001008,
                      1,1,1,64'h80001000,32'hB0,0));
      tv.push_back(mk(0,1,64'h80002000,0,0,0,0,1, 0,0, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,0,0,1, 1,64'h80002000, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,1,32'hDEAD0001,0,1, 0,0, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,1,32'hC0,0,1, 1,64'h80002004, 1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,0,0,1, 1,64'h80002004,
                      1,1,1,64'h80002000,32'hC0,0));
      tv.push_back(mk(1,0,0,0,0,0,0,1, 0,0, 1,0,1,0,0,0));
      tv.push_back(mk(0,0,0,1,0,0,0,1, 1,64'h80000000, 1,0,1,0,0,0));

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         rst            = tv[i].rst;
         redirect_valid = tv[i].rdv;
         redirect_pc    = tv[i].rpc;
         mem_req_ready  = tv[i].rdy;
         mem_resp_valid = tv[i].rv;
         mem_resp_inst  = tv[i].ri;
         mem_resp_err   = tv[i].re;
         id_ready       = tv[i].idr;
         #1;
         chk($sformatf("tv%0d_req_valid", i), mem_req_valid, tv[i].erv);
         if (tv[i].erv)
            chk($sformatf("tv%0d_req_pc", i), mem_req_pc, tv[i].epc);
         if (tv[i].civ)
            chk($sformatf("tv%0d_id_valid", i), id_valid, tv[i].eiv);
         if (tv[i].cid) begin
            chk($sformatf("tv%0d_id_pc", i), id_pc, tv[i].eipc);
            chk($sformatf("tv%0d_id_inst", i), id_inst, tv[i].einst);
            chk($sformatf("tv%0d_id_fault", i), id_fault, tv[i].eflt);
         end
      end

      // streaming with a 1-cycle ICACHE: one instruction per cycle
      lat_lo = 1; lat_hi = 1;
      cycle(1, 0, 0, 1, 1);
      repeat (4) cycle(0, 0, 0, 1, 1);
      n_id = 0;
      repeat (20) cycle(0, 0, 0, 1, 1);
      chk("steady_rate", 64'(n_id), 64'd20);

      // ID stalls: queue fills, fetch stops, then drains in order
      repeat (20) cycle(0, 0, 0, 1, 0);
      chk("fill_req_off", mem_req_valid, 1'b0);
      chk("fill_head_valid", id_valid, 1'b1);
      repeat (20) cycle(0, 0, 0, 1, 1);

      // round trip of three cycles: two fetches per three cycles
      lat_lo = 2; lat_hi = 2;
      cycle(1, 0, 0, 1, 1);
      repeat (6) cycle(0, 0, 0, 1, 1);
      n_id = 0;
      repeat (24) cycle(0, 0, 0, 1, 1);
      chk("lat3_rate", 64'(n_id), 64'd16);

      // redirect with two fetches in flight
      lat_lo = 3; lat_hi = 3;
      cycle(1, 0, 0, 1, 1);
      repeat (2) cycle(0, 0, 0, 1, 1);
      seen = 1'b0;
      cycle(0, 1, 64'h80001002, 1, 1);
      repeat (12) cycle(0, 0, 0, 1, 1);
      chk("redir_seen", seen, 1'b1);
      chk("redir_first_pc", first_pc, 64'h80001000);

      // PC wraps past the top of the address space
      lat_lo = 1; lat_hi = 1;
      cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
      repeat (8) cycle(0, 0, 0, 1, 1);

      // random latency, back-pressure, redirects and resets
      lat_lo = 1; lat_hi = 4;
      cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 29) == 0,
               {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_3FFF)},
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
